// File: rtl/parity_gen_chk_seq.sv
// parity_gen_chk_seq
//   Clocked per-word and per-frame parity generator/checker. Each accepted
//   word (DV=1) gets its even/odd parity reported one cycle later. The words of
//   a multi-word frame are folded into a 1-bit accumulator. The frame closes on
//   DV&LAST, and its data parity is compared against CHK. Completed frames
//   (FCNT, wrapping) and failed frames (ERRCNT, saturating) are counted.
//
// Ports
//   CLK, RST    rising-edge clock, synchronous active-high reset
//   D, DV       data word and its valid qualifier
//   LAST, CHK   end-of-frame marker and frame check bit (only used with DV)
//   CLR         synchronous clear of ERRCNT/FCNT
//   WEV/WODD    parity of the last accepted word; WVLD pulses when it updates
//   FEV/FODD    data parity of the last completed frame; FVLD pulses on completion
//   ERR         pulses with FVLD when the frame check fails
//   BUSY        a frame is open (ACTIVE)
//   ERRCNT/FCNT failed / completed frame counters
module parity_gen_chk_seq #(
    parameter int WIDTH     = 8,
    parameter bit ODD_SENSE = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    input  logic             LAST,
    input  logic             CHK,
    input  logic             CLR,
    output logic             WEV,
    output logic             WODD,
    output logic             WVLD,
    output logic             FEV,
    output logic             FODD,
    output logic             FVLD,
    output logic             ERR,
    output logic             BUSY,
    output logic [CNT_W-1:0] ERRCNT,
    output logic [CNT_W-1:0] FCNT
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             acc_q, acc_d;
    logic             wev_q, wev_d, wodd_q, wodd_d, wvld_q, wvld_d;
    logic             fev_q, fev_d, fodd_q, fodd_d, fvld_q, fvld_d;
    logic             err_q, err_d, busy_q, busy_d;
    logic [CNT_W-1:0] errcnt_q, errcnt_d, fcnt_q, fcnt_d;

    logic word_par;  // 1 = odd number of ones in D
    logic nxt;       // frame parity including the current word

    assign word_par = ^D;
    assign nxt      = acc_q ^ word_par;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        wev_d    = wev_q;
        wodd_d   = wodd_q;
        wvld_d   = 1'b0;
        fev_d    = fev_q;
        fodd_d   = fodd_q;
        fvld_d   = 1'b0;
        err_d    = 1'b0;
        errcnt_d = errcnt_q;
        fcnt_d   = fcnt_q;

        if (DV) begin
            wodd_d = word_par;
            wev_d  = ~word_par;
            wvld_d = 1'b1;
            if (LAST) begin
                // Frame closes. The accumulator restarts so a back-to-back
                // frame on the next cycle begins from zero.
                acc_d   = 1'b0;
                state_d = IDLE;
                fodd_d  = nxt;
                fev_d   = ~nxt;
                fvld_d  = 1'b1;
                err_d   = ((nxt ^ CHK) != ODD_SENSE);
                fcnt_d  = fcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (err_d && (errcnt_q != CNT_MAX))
                    errcnt_d = errcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                acc_d   = nxt;
                state_d = ACTIVE;
            end
        end

        // A clear drops any increment from this cycle. The pulses are not affected.
        if (CLR) begin
            errcnt_d = '0;
            fcnt_d   = '0;
        end

        busy_d = (state_d == ACTIVE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            acc_q    <= 1'b0;
            wev_q    <= 1'b0;
            wodd_q   <= 1'b0;
            wvld_q   <= 1'b0;
            fev_q    <= 1'b0;
            fodd_q   <= 1'b0;
            fvld_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            errcnt_q <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            wev_q    <= wev_d;
            wodd_q   <= wodd_d;
            wvld_q   <= wvld_d;
            fev_q    <= fev_d;
            fodd_q   <= fodd_d;
            fvld_q   <= fvld_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            errcnt_q <= errcnt_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign WEV    = wev_q;
    assign WODD   = wodd_q;
    assign WVLD   = wvld_q;
    assign FEV    = fev_q;
    assign FODD   = fodd_q;
    assign FVLD   = fvld_q;
    assign ERR    = err_q;
    assign BUSY   = busy_q;
    assign ERRCNT = errcnt_q;
    assign FCNT   = fcnt_q;

endmodule

// File: doc/parity_gen_chk_seq.md
Name: parity_gen_chk_seq

Overview:
Parametrised, clocked successor to the 3-input even/odd parity function blocks. Computes per-word even/odd parity of a WIDTH-bit data word and accumulates parity across multi-word frames. Checks each frame against a supplied check bit and keeps saturating error and frame counters. Sits between a parallel data source and the display/indicator logic on the lab board.

Parameters:
WIDTH, 8, data word width in bits (>=2)
ODD_SENSE, 0, 0 = even-parity frames (data ones + CHK must be even); 1 = odd-parity frames
CNT_W, 8, width of ERRCNT and FCNT

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
D  input  WIDTH  data word
DV  input  1  data valid; D, LAST and CHK are sampled only when DV=1
LAST  input  1  marks final word of a frame (qualified by DV)
CHK  input  1  frame check bit (qualified by DV&LAST)
CLR  input  1  synchronous clear of ERRCNT and FCNT only
WEV  output  1  word parity: 1 = even number of ones in last accepted D
WODD  output  1  word parity: 1 = odd number of ones; always ~WEV once WVLD has been seen
WVLD  output  1  one-cycle pulse, WEV/WODD updated
FEV  output  1  frame data parity even (CHK excluded)
FODD  output  1  frame data parity odd
FVLD  output  1  one-cycle pulse, frame completed
ERR  output  1  one-cycle pulse coincident with FVLD when frame check fails
BUSY  output  1  1 while a frame is open (ACTIVE state)
ERRCNT  output  CNT_W  count of failed frames, saturating
FCNT  output  CNT_W  count of completed frames, wraps

Behaviour:
- Reset (RST=1 at edge): every output 0, including WEV, WODD, FEV, FODD and both counters. Accumulator cleared. State goes to IDLE. RST overrides every other input.
- Word path, latency 1:
  - DV=1 at edge N: at N+1, WODD = XOR-reduce(D), WEV = ~WODD, WVLD = 1.
  - DV=0: WVLD = 0; WEV and WODD hold their values.
- Accumulator ACC (1 bit): nxt = ACC ^ XOR-reduce(D).
  - On DV&~LAST: ACC <= nxt.
  - On DV&LAST: ACC <= 0.
- Frame completion on DV&LAST, latency 1:
  - FODD = nxt, FEV = ~nxt, FVLD = 1.
  - ERR = 1 if (nxt ^ CHK) != ODD_SENSE.
  - FEV/FODD hold between frames. FVLD and ERR are otherwise 0.
- FSM:
  - IDLE: DV&~LAST -> ACTIVE. DV&LAST -> IDLE (a single-word frame still completes with FVLD).
  - ACTIVE: DV&LAST -> IDLE. Otherwise stays in ACTIVE.
  - BUSY = (state == ACTIVE), registered.
- LAST or CHK with DV=0: ignored, no state change.
- Gaps: any number of DV=0 cycles is allowed inside a frame. ACC and state hold.
- Counters:
  - FCNT increments on every frame completion and wraps from all-ones to 0.
  - ERRCNT increments on each ERR and saturates at all-ones.
  - Counters update in the same cycle as FVLD/ERR.
- CLR=1: FCNT and ERRCNT go to 0 next cycle. CLR wins over a simultaneous increment: that frame is not counted. FVLD and ERR still pulse. Word and frame paths are unaffected.
- RST mid-frame: partial frame is discarded. No FVLD, no ERR, no count.
- Back-to-back frames, i.e. DV&LAST on consecutive cycles, are each completed independently. Full throughput is one word per cycle with no stall.

Test Plan:
1. RST held 2 cycles, then released -> all outputs 0, BUSY=0, counters 0.
2. WIDTH=8, DV with D=0x00, 0x01, 0x03, 0x07 on successive cycles -> WEV/WODD = 1/0, 0/1, 1/0, 0/1 one cycle after each; WVLD high 4 cycles.
3. Frame D=0x0F, DV-gap 3 cycles, D=0x01 with LAST=1, CHK=1, ODD_SENSE=0 -> BUSY=1 after first word and through the gap; FODD=1, FVLD=1, ERR=0, FCNT=1, BUSY=0.
4. Single-word frame D=0x03, LAST=1, CHK=1 -> FEV=1, ERR=1, ERRCNT=1; next cycle frame D=0x01, LAST=1, CHK=1 -> ERR=0, FCNT=3.
5. CNT_W=2: four failing single-word frames -> ERRCNT 1,2,3,3; FCNT 1,2,3,0. CLR asserted with a fifth failing frame -> ERR pulses, both counters 0.
6. Open frame (one word, BUSY=1), RST pulse, then LAST word D=0x01, CHK=0 -> no FVLD during reset; afterwards FVLD with FODD=1 (fresh accumulator), ERR=1, FCNT=1.
